// File: rtl/div_cascade_ctrl_if.sv
// Control/status bundle for the divider cascade sequencer.
// Optional lap-capture signals exist only when DIV_CASCADE_LAP_EN is defined.
interface div_cascade_ctrl_if;
  logic       strobe;
  logic       start;
  logic       stop;
  logic       clr;
  logic [3:0] lo_cnt;
  logic [3:0] hi_cnt;
  logic       lo_wrap;
  logic       hi_wrap;
  logic       running;
`ifdef DIV_CASCADE_LAP_EN
  logic       lap;
  logic [3:0] lap_lo;
  logic [3:0] lap_hi;
`endif

  modport master (
    output strobe, start, stop, clr,
`ifdef DIV_CASCADE_LAP_EN
    output lap,
    input  lap_lo, lap_hi,
`endif
    input  lo_cnt, hi_cnt, lo_wrap, hi_wrap, running
  );

  modport slave (
    input  strobe, start, stop, clr,
`ifdef DIV_CASCADE_LAP_EN
    input  lap,
    output lap_lo, lap_hi,
`endif
    output lo_cnt, hi_cnt, lo_wrap, hi_wrap, running
  );
endinterface

// File: rtl/div_cascade_ctrl.sv
// Stopwatch timebase: IDLE/RUN/PAUSE run control over a two-digit modulo cascade.
// Define DIV_CASCADE_LAP_EN to add lap capture registers.
module div_cascade_ctrl #(
  parameter int unsigned DIV_LO = 3,
  parameter int unsigned DIV_HI = 6
) (
  input  logic              clk,
  input  logic              rst,
  div_cascade_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_e;

  localparam logic [3:0] LO_MAX = 4'(DIV_LO - 1);
  localparam logic [3:0] HI_MAX = 4'(DIV_HI - 1);

  state_e     state_q, state_d;
  logic [3:0] lo_q, lo_d, hi_q, hi_d;
  logic       lo_wrap_q, lo_wrap_d, hi_wrap_q, hi_wrap_d;
  logic       ce, run_dec;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // stop outranks start, so a coincident pair never leaves IDLE/PAUSE
  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (bus.start && !bus.stop) state_d = RUN;
        RUN:     if (bus.stop)               state_d = PAUSE;
        PAUSE:   if (bus.start && !bus.stop) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    run_dec = (state_q == RUN);
    ce      = run_dec && bus.strobe && !bus.clr;
  end

  always_comb begin
    lo_d      = lo_q;
    hi_d      = hi_q;
    lo_wrap_d = 1'b0;
    hi_wrap_d = 1'b0;
    if (bus.clr) begin
      lo_d = 4'd0;
      hi_d = 4'd0;
    end else if (ce) begin
      if (lo_q == LO_MAX) begin
        lo_d      = 4'd0;
        lo_wrap_d = 1'b1;
        if (hi_q == HI_MAX) begin
          hi_d      = 4'd0;
          hi_wrap_d = 1'b1;
        end else begin
          hi_d = hi_q + 4'd1;
        end
      end else begin
        lo_d = lo_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q      <= 4'd0;
      hi_q      <= 4'd0;
      lo_wrap_q <= 1'b0;
      hi_wrap_q <= 1'b0;
    end else begin
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      lo_wrap_q <= lo_wrap_d;
      hi_wrap_q <= hi_wrap_d;
    end
  end

  assign bus.lo_cnt  = lo_q;
  assign bus.hi_cnt  = hi_q;
  assign bus.lo_wrap = lo_wrap_q;
  assign bus.hi_wrap = hi_wrap_q;
  assign bus.running = run_dec;

`ifdef DIV_CASCADE_LAP_EN
  logic [3:0] lap_lo_q, lap_lo_d, lap_hi_q, lap_hi_d;

  // snapshot is of the pre-update counts, alongside any coincident strobe
  always_comb begin
    lap_lo_d = lap_lo_q;
    lap_hi_d = lap_hi_q;
    if (bus.clr) begin
      lap_lo_d = 4'd0;
      lap_hi_d = 4'd0;
    end else if (bus.lap && state_q != IDLE) begin
      lap_lo_d = lo_q;
      lap_hi_d = hi_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_lo_q <= 4'd0;
      lap_hi_q <= 4'd0;
    end else begin
      lap_lo_q <= lap_lo_d;
      lap_hi_q <= lap_hi_d;
    end
  end

  assign bus.lap_lo = lap_lo_q;
  assign bus.lap_hi = lap_hi_q;
`endif
endmodule
